// File: rtl/ann_layer_sequencer_if.sv
// Control bundle between the layer sequencer and its neighbours
// (memory loader, neuron array, layer output registers).
// master: sequencer side (drives strobes/status); slave: environment side.
// Ports: start_detecting, data_loaded, layer_done, abort (into sequencer);
//        max_input, coeff_ready, reset_accum, load_next, request_coef,
//        coef_select, cur_layer, done_processing, busy, timeout_err (out).
interface ann_layer_sequencer_if #(
  parameter int SIZE_W = 7,
  parameter int SEL_W  = 2
);
  logic              start_detecting;
  logic              data_loaded;
  logic              layer_done;
  logic              abort;
  logic [SIZE_W-1:0] max_input;
  logic              coeff_ready;
  logic              reset_accum;
  logic [SEL_W-1:0]  load_next;
  logic              request_coef;
  logic [SEL_W-1:0]  coef_select;
  logic [SEL_W-1:0]  cur_layer;
  logic              done_processing;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  start_detecting, data_loaded, layer_done, abort,
    output max_input, coeff_ready, reset_accum, load_next, request_coef,
           coef_select, cur_layer, done_processing, busy, timeout_err
  );

  modport slave (
    output start_detecting, data_loaded, layer_done, abort,
    input  max_input, coeff_ready, reset_accum, load_next, request_coef,
           coef_select, cur_layer, done_processing, busy, timeout_err
  );
endinterface

// File: rtl/ann_layer_sequencer.sv
// Purpose: steps one image pass through NUM_LAYERS layers (image load, per-layer coefficient fetch, compute, capture).
// Latency: all strobes/status registered, one cycle after the input that causes the state change; max_input follows cur_layer.
// Backpressure: none; the FSM waits in REQ_IMAGE/WAIT_COEF/WAIT_LAYER for data_loaded/layer_done, abort always wins.
// Ports: clk, n_rst (async active-low), bus (ann_layer_sequencer_if.master).
// Optional: define ANN_SEQ_WATCHDOG_EN to bound the three wait states by TIMEOUT_CYCLES
// (timeout -> IDLE and sticky timeout_err); without it waits are unbounded and timeout_err is 0.
module ann_layer_sequencer #(
  parameter int                           NUM_LAYERS     = 3,
  parameter int                           SIZE_W         = 7,
  parameter logic [NUM_LAYERS*SIZE_W-1:0] LAYER_IN_SIZES = {7'd8, 7'd16, 7'd64},
  parameter int                           TIMEOUT_CYCLES = 1023
) (
  input logic                   clk,
  input logic                   n_rst,
  ann_layer_sequencer_if.master bus
);
  localparam int               SEL_W   = $clog2(NUM_LAYERS + 1);
  localparam logic [SEL_W-1:0] IMG_SEL = '1;

  if (NUM_LAYERS < 1 || NUM_LAYERS > 7 || SIZE_W < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("ann_layer_sequencer: parameter out of range");
  end

  typedef enum logic [3:0] {
    IDLE, REQ_IMAGE, LOAD_IMAGE, REQ_COEF, WAIT_COEF, PAUSE_COEF,
    START_LAYER, WAIT_LAYER, INCR_LAYER, CHECK_DONE, DONE
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  cur_layer;
  logic [SEL_W-1:0]  coef_select;
  logic [SEL_W-1:0]  load_next;
  logic              request_coef;
  logic              reset_accum;
  logic              coeff_ready;
  logic              done_processing;
  logic              busy;
  logic              wd_expired;
  logic              timeout_err_q;
  logic [SIZE_W-1:0] max_input_c;

`ifdef ANN_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_wait;

  // A wait state that is not being left this cycle; leaving (or any other
  // state) clears the count, which gives "clear on every state change".
  assign wd_wait = ((state == REQ_IMAGE || state == WAIT_COEF) && !bus.data_loaded) ||
                   (state == WAIT_LAYER && !bus.layer_done);
  // Fires on the cycle whose edge would bring the count to TIMEOUT_CYCLES.
  assign wd_expired = wd_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (wd_wait && !bus.abort && !wd_expired) wd_cnt <= wd_cnt + WD_W'(1);
      else                                      wd_cnt <= '0;
      if (wd_expired && !bus.abort)
        timeout_err_q <= 1'b1;
      else if (state == IDLE && bus.start_detecting && !bus.abort)
        timeout_err_q <= 1'b0;
    end
  end
`else
  assign wd_expired    = 1'b0;
  assign timeout_err_q = 1'b0;
`endif

  // Outputs are registered on the transition into the state that owns them,
  // so each strobe is high for exactly the one cycle spent in that state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= IDLE;
      cur_layer       <= '0;
      coef_select     <= '0;
      load_next       <= '0;
      request_coef    <= 1'b0;
      reset_accum     <= 1'b0;
      coeff_ready     <= 1'b0;
      done_processing <= 1'b0;
      busy            <= 1'b0;
    end else begin
      load_next       <= '0;
      request_coef    <= 1'b0;
      reset_accum     <= 1'b0;
      done_processing <= 1'b0;
      if (bus.abort || wd_expired) begin
        // Also covers abort in IDLE: start is ignored that cycle.
        state       <= IDLE;
        cur_layer   <= '0;
        coeff_ready <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start_detecting) begin
            state       <= REQ_IMAGE;
            coef_select <= IMG_SEL;
            coeff_ready <= 1'b1;
            busy        <= 1'b1;
          end
          REQ_IMAGE: if (bus.data_loaded) begin
            state       <= LOAD_IMAGE;
            coeff_ready <= 1'b0;
            load_next   <= IMG_SEL;
          end
          LOAD_IMAGE: begin
            state        <= REQ_COEF;
            request_coef <= 1'b1;
            coef_select  <= cur_layer;
          end
          REQ_COEF:  state <= WAIT_COEF;
          WAIT_COEF: if (bus.data_loaded) state <= PAUSE_COEF;
          PAUSE_COEF: begin
            state       <= START_LAYER;
            reset_accum <= 1'b1;
          end
          START_LAYER: begin
            state       <= WAIT_LAYER;
            coeff_ready <= 1'b1;
          end
          WAIT_LAYER: if (bus.layer_done) begin
            state       <= INCR_LAYER;
            coeff_ready <= 1'b0;
            load_next   <= cur_layer + SEL_W'(1);
          end
          INCR_LAYER: begin
            state     <= CHECK_DONE;
            cur_layer <= cur_layer + SEL_W'(1);
          end
          CHECK_DONE: if (cur_layer == SEL_W'(NUM_LAYERS)) begin
            state           <= DONE;
            done_processing <= 1'b1;
          end else begin
            state        <= REQ_COEF;
            request_coef <= 1'b1;
            coef_select  <= cur_layer;
          end
          DONE: begin
            state     <= IDLE;
            cur_layer <= '0;
            busy      <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            cur_layer   <= '0;
            coeff_ready <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

  // cur_layer == NUM_LAYERS (CHECK_DONE/DONE) keeps the last layer's size.
  always_comb begin
    max_input_c = LAYER_IN_SIZES[(NUM_LAYERS-1)*SIZE_W +: SIZE_W];
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (cur_layer == SEL_W'(k)) max_input_c = LAYER_IN_SIZES[k*SIZE_W +: SIZE_W];
    end
  end

  assign bus.max_input       = max_input_c;
  assign bus.coeff_ready     = coeff_ready;
  assign bus.reset_accum     = reset_accum;
  assign bus.load_next       = load_next;
  assign bus.request_coef    = request_coef;
  assign bus.coef_select     = coef_select;
  assign bus.cur_layer       = cur_layer;
  assign bus.done_processing = done_processing;
  assign bus.busy            = busy;
  assign bus.timeout_err     = timeout_err_q;
endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Bench for ann_layer_sequencer: default 3-layer instance checked through an
// event scoreboard, plus a 1-layer instance checked directly.
module tb_ann_layer_sequencer;
  logic clk;
  logic n_rst;

  ann_layer_sequencer_if #(.SIZE_W(7), .SEL_W(2)) bus ();
  ann_layer_sequencer_if #(.SIZE_W(7), .SEL_W(1)) bus1 ();

  ann_layer_sequencer #(.TIMEOUT_CYCLES(10)) u_dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  ann_layer_sequencer #(.NUM_LAYERS(1), .LAYER_IN_SIZES(7'd32), .TIMEOUT_CYCLES(10)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .bus(bus1)
  );

  typedef struct packed {
    logic [1:0] load_next;
    logic       request_coef;
    logic [1:0] coef_select;
    logic       reset_accum;
    logic       done_processing;
    logic [6:0] max_input;
    logic [1:0] cur_layer;
  } ev_t;

  ev_t exp_q [$];
  ev_t obs;
  ev_t exp_ev;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  rc1_cnt  = 0;
  int  exp_max [3] = '{64, 16, 8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic ev_t mk(input int ln, rc, cs, ra, dp, mx, cl);
    ev_t e;
    e.load_next = 2'(ln); e.request_coef = 1'(rc); e.coef_select = 2'(cs);
    e.reset_accum = 1'(ra); e.done_processing = 1'(dp);
    e.max_input = 7'(mx); e.cur_layer = 2'(cl);
    return e;
  endfunction

  // Monitor: every cycle with a strobe is one event, compared in order.
  always @(negedge clk) begin
    if (n_rst && (bus.load_next != 2'd0 || bus.request_coef || bus.reset_accum || bus.done_processing)) begin
      obs = {bus.load_next, bus.request_coef, bus.coef_select, bus.reset_accum,
             bus.done_processing, bus.max_input, bus.cur_layer};
      check("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_ev = exp_q.pop_front();
        check("event", 32'(obs), 32'(exp_ev));
      end
    end
    if (n_rst && bus1.request_coef) rc1_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit sig_now(input int which);
    case (which)
      0:       return bus.request_coef;
      1:       return bus.reset_accum;
      default: return bus.done_processing;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name);
    int n = 0;
    while (!sig_now(which) && n < 60) begin
      tick(1);
      n++;
    end
    if (!sig_now(which)) check(name, 32'd0, 32'd1);
  endtask

  task automatic start_and_image();
    bus.start_detecting = 1'b1;
    tick(1);
    bus.start_detecting = 1'b0;
    check("req_image_busy", 32'(bus.busy), 32'd1);
    check("req_image_coeff_ready", 32'(bus.coeff_ready), 32'd1);
    check("req_image_coef_select", 32'(bus.coef_select), 32'd3);
    tick(2);
    bus.data_loaded = 1'b1;
    tick(1);
    bus.data_loaded = 1'b0;
  endtask

  // stop_kind: 0 full pass, 1 abort, 2 reset, in WAIT_LAYER of stop_layer.
  task automatic run_pass(input int stop_layer, input int stop_kind, input bit spurious);
    exp_q.push_back(mk(3, 0, 3, 0, 0, 64, 0));
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(0, 1, k, 0, 0, exp_max[k], k));
      exp_q.push_back(mk(0, 0, k, 1, 0, exp_max[k], k));
      if (stop_kind != 0 && k == stop_layer) break;
      exp_q.push_back(mk(k + 1, 0, k, 0, 0, exp_max[k], k));
    end
    if (stop_kind == 0) exp_q.push_back(mk(0, 0, 2, 0, 1, 8, 3));

    start_and_image();
    for (int k = 0; k < 3; k++) begin
      wait_sig(0, "wait_request_coef");
      tick(1);
      if (spurious && k == 0) bus.layer_done = 1'b1;
      tick(1);
      bus.layer_done = 1'b0;
      if (spurious && k == 0) check("wait_coef_ignores_layer_done", 32'(bus.coeff_ready), 32'd0);
      bus.data_loaded = 1'b1;
      tick(1);
      bus.data_loaded = 1'b0;
      wait_sig(1, "wait_reset_accum");
      tick(2);
      if (stop_kind == 1 && k == stop_layer) begin
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_cur_layer", 32'(bus.cur_layer), 32'd0);
        check("abort_coeff_ready", 32'(bus.coeff_ready), 32'd0);
        tick(4);
        return;
      end
      if (stop_kind == 2 && k == stop_layer) begin
        n_rst = 1'b0;
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cur_layer", 32'(bus.cur_layer), 32'd0);
        check("rst_coef_select", 32'(bus.coef_select), 32'd0);
        check("rst_coeff_ready", 32'(bus.coeff_ready), 32'd0);
        check("rst_max_input", 32'(bus.max_input), 32'd64);
        @(negedge clk);
        n_rst = 1'b1;
        tick(2);
        return;
      end
      if (spurious && k == 0) bus.data_loaded = 1'b1;
      tick(1);
      bus.data_loaded = 1'b0;
      if (spurious && k == 0) check("wait_layer_ignores_data_loaded", 32'(bus.coeff_ready), 32'd1);
      tick(2);
      bus.layer_done = 1'b1;
      tick(1);
      bus.layer_done = 1'b0;
    end
    wait_sig(2, "wait_done");
    tick(1);
    check("pass_end_busy", 32'(bus.busy), 32'd0);
    check("pass_end_cur_layer", 32'(bus.cur_layer), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0;
    bus.start_detecting = 1'b0; bus.data_loaded = 1'b0; bus.layer_done = 1'b0; bus.abort = 1'b0;
    bus1.start_detecting = 1'b0; bus1.data_loaded = 1'b0; bus1.layer_done = 1'b0; bus1.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_cur_layer", 32'(bus.cur_layer), 32'd0);
    check("reset_coef_select", 32'(bus.coef_select), 32'd0);
    check("reset_max_input", 32'(bus.max_input), 32'd64);
    check("reset_load_next", 32'(bus.load_next), 32'd0);
    check("reset_timeout_err", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick(2);

    // abort in IDLE blocks a simultaneous start
    bus.start_detecting = 1'b1;
    bus.abort = 1'b1;
    tick(1);
    bus.start_detecting = 1'b0;
    bus.abort = 1'b0;
    check("abort_blocks_start", 32'(bus.busy), 32'd0);
    tick(2);

    run_pass(0, 0, 1'b0);
    run_pass(0, 0, 1'b1);
    run_pass(1, 1, 1'b0);
    run_pass(0, 0, 1'b0);
    run_pass(2, 2, 1'b0);

    // Coefficients withheld in WAIT_COEF
    exp_q.push_back(mk(3, 0, 3, 0, 0, 64, 0));
    exp_q.push_back(mk(0, 1, 0, 0, 0, 64, 0));
    start_and_image();
    wait_sig(0, "wait_request_coef");
`ifdef ANN_SEQ_WATCHDOG_EN
    tick(10);
    check("wd_still_waiting", 32'(bus.busy), 32'd1);
    tick(1);
    check("wd_idle", 32'(bus.busy), 32'd0);
    check("wd_cur_layer", 32'(bus.cur_layer), 32'd0);
    check("wd_timeout_err", 32'(bus.timeout_err), 32'd1);
    tick(3);
    check("wd_timeout_err_sticky", 32'(bus.timeout_err), 32'd1);
    run_pass(0, 0, 1'b0);
    check("wd_timeout_err_cleared", 32'(bus.timeout_err), 32'd0);
`else
    tick(20);
    check("unbounded_wait_busy", 32'(bus.busy), 32'd1);
    check("no_timeout_err", 32'(bus.timeout_err), 32'd0);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("unbounded_wait_abort", 32'(bus.busy), 32'd0);
`endif

    // Single-layer instance, including start held across DONE
    bus1.start_detecting = 1'b1;
    tick(1);
    bus1.start_detecting = 1'b0;
    check("l1_img_coef_select", 32'(bus1.coef_select), 32'd1);
    bus1.data_loaded = 1'b1;
    tick(1);
    bus1.data_loaded = 1'b0;
    check("l1_load_image", 32'(bus1.load_next), 32'd1);
    tick(1);
    check("l1_request_coef", 32'(bus1.request_coef), 32'd1);
    check("l1_coef_select", 32'(bus1.coef_select), 32'd0);
    check("l1_max_input", 32'(bus1.max_input), 32'd32);
    tick(1);
    bus1.data_loaded = 1'b1;
    tick(1);
    bus1.data_loaded = 1'b0;
    tick(1);
    check("l1_reset_accum", 32'(bus1.reset_accum), 32'd1);
    tick(1);
    check("l1_wait_layer_coeff_ready", 32'(bus1.coeff_ready), 32'd1);
    bus1.layer_done = 1'b1;
    tick(1);
    bus1.layer_done = 1'b0;
    check("l1_incr_load_next", 32'(bus1.load_next), 32'd1);
    tick(1);
    check("l1_check_cur_layer", 32'(bus1.cur_layer), 32'd1);
    check("l1_check_max_input", 32'(bus1.max_input), 32'd32);
    tick(1);
    check("l1_done", 32'(bus1.done_processing), 32'd1);
    bus1.start_detecting = 1'b1;
    tick(1);
    check("l1_idle_after_done", 32'(bus1.busy), 32'd0);
    check("l1_cur_layer_cleared", 32'(bus1.cur_layer), 32'd0);
    tick(1);
    check("l1_restart_busy", 32'(bus1.busy), 32'd1);
    bus1.start_detecting = 1'b0;
    bus1.abort = 1'b1;
    tick(1);
    bus1.abort = 1'b0;
    check("l1_abort_req_image", 32'(bus1.busy), 32'd0);
    check("l1_single_request", 32'(rc1_cnt), 32'd1);

    tick(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end
endmodule
